// File: rtl/nor_pkg.sv
// Shared definitions for the NOR gate sweep self-test.
// State encoding, vector count and ideal truth table.
package nor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    localparam logic [NUM_VECTORS-1:0] EXPECTED_TT = 8'h01;

endpackage

// File: rtl/nor_hold_timer.sv
// Down-counter timing how long each vector is held.
// Loads a start value, counts down to zero and stops there.
module nor_hold_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    // load takes priority; otherwise count down and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !zero) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/nor_sweep_ctrl.sv
// Self-test sequencer for the 3-input NOR gate.
// Walks all 8 vectors, samples the gate and scores the result.
module nor_sweep_ctrl
    import nor_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       s_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int TW       = $clog2(HOLD_EFF) + 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             hold_zero;
    logic             hold_load;
    logic             hold_en;
    logic             mism;
    logic             last;
    logic             go;

    assign go   = (state == ST_IDLE) && start && !abort;
    assign mism = (s_in != ~|idx);
    assign last = (idx == IDX_W'(NUM_VECTORS - 1));

    assign hold_en   = (state == ST_RUN) && !abort;
    assign hold_load = go || (hold_en && hold_zero && !last);

    nor_hold_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .load_val (TW'(HOLD_EFF - 1)),
        .en       (hold_en),
        .zero     (hold_zero)
    );

    // sweep FSM with registered gate inputs and scoring results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            {a, b, c}  <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            tt         <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        state      <= ST_RUN;
                        idx        <= '0;
                        {a, b, c}  <= 3'b000;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        tt         <= '0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        {a, b, c} <= 3'b000;
                    end else if (hold_zero) begin
                        tt[idx] <= s_in;
                        if (mism) begin
                            err_cnt <= err_cnt + 4'd1;
                            if (!fail_valid) begin
                                first_fail <= idx;
                                fail_valid <= 1'b1;
                            end
                        end
                        if (last) begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            {a, b, c} <= 3'b000;
                            pass      <= (err_cnt == 4'd0) && !mism;
                        end else begin
                            idx       <= idx + 3'd1;
                            {a, b, c} <= idx + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor_sweep_ctrl.sv
// Bench for the NOR sweep controller with hold of 1 and 3.
// Results are scored against a queue of modelled sweeps.
module tb_nor_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start1, abort1, start3, abort3;
    int   mode;
    logic s1, s3;

    logic       a1, b1, c1, busy1, done1, pass1, fv1;
    logic [7:0] tt1;
    logic [3:0] err1;
    logic [2:0] ff1;
    logic       a3, b3, c3, busy3, done3, pass3, fv3;
    logic [7:0] tt3;
    logic [3:0] err3;
    logic [2:0] ff3;

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [3:0] err;
        logic [2:0] ff;
        logic       fv;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int checks = 0;
    int errors = 0;
    int dcnt1  = 0;
    int dcnt3  = 0;

    // gate stand-in: 0 = real NOR, 1 = stuck at 0, 2 = stuck at 1
    function automatic logic gate_out(input int m, input logic [2:0] v);
        if (m == 0) return ~(v[2] | v[1] | v[0]);
        if (m == 1) return 1'b0;
        return 1'b1;
    endfunction

    assign s1 = gate_out(mode, {a1, b1, c1});
    assign s3 = gate_out(mode, {a3, b3, c3});

    nor_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .s_in(s1), .a(a1), .b(b1), .c(c1), .busy(busy1),
        .done(done1), .pass(pass1), .tt(tt1), .err_cnt(err1),
        .first_fail(ff1), .fail_valid(fv1)
    );

    nor_sweep_ctrl #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .s_in(s3), .a(a3), .b(b3), .c(c3), .busy(busy3),
        .done(done3), .pass(pass3), .tt(tt3), .err_cnt(err3),
        .first_fail(ff3), .fail_valid(fv3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int m);
        exp_t e;
        logic s;
        logic [2:0] v;
        e.tt = '0; e.err = '0; e.ff = '0; e.fv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            s = gate_out(m, v);
            e.tt[i] = s;
            if (s != (i == 0)) begin
                e.err = e.err + 4'd1;
                if (!e.fv) begin
                    e.ff = v;
                    e.fv = 1'b1;
                end
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    // scoreboard: each done pulse pops one expected sweep result
    always @(negedge clk) begin
        if (done1) begin
            dcnt1++;
            check("sb1_pending", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("sb1_tt", tt1, e1.tt);
                check("sb1_pass", pass1, e1.pass);
                check("sb1_err", err1, e1.err);
                check("sb1_ff", ff1, e1.ff);
                check("sb1_fv", fv1, e1.fv);
            end
        end
        if (done3) begin
            dcnt3++;
            check("sb3_pending", q3.size() > 0, 1);
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                check("sb3_tt", tt3, e3.tt);
                check("sb3_pass", pass3, e3.pass);
                check("sb3_err", err3, e3.err);
                check("sb3_ff", ff3, e3.ff);
                check("sb3_fv", fv3, e3.fv);
            end
        end
    end

    function automatic logic [2:0] abc_of(input int sel);
        return (sel == 1) ? {a1, b1, c1} : {a3, b3, c3};
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 1) ? busy1 : busy3;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 1) ? done1 : done3;
    endfunction

    function automatic logic pass_of(input int sel);
        return (sel == 1) ? pass1 : pass3;
    endfunction

    function automatic int dcnt_of(input int sel);
        return (sel == 1) ? dcnt1 : dcnt3;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start1 = v;
        else start3 = v;
    endtask

    task automatic sweep(input int sel, input int m, input int hold,
                         input bit repulse);
        exp_t e;
        int d0;
        mode = m;
        e = model(m);
        if (sel == 1) q1.push_back(e);
        else q3.push_back(e);
        d0 = dcnt_of(sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < hold; k++) begin
                check($sformatf("abc_d%0d_m%0d_v%0d_k%0d", sel, m, i, k),
                      abc_of(sel), i);
                check($sformatf("busy_d%0d_v%0d_k%0d", sel, i, k),
                      busy_of(sel), 1);
                set_start(sel, repulse && i == 3 && k == 0);
                @(posedge clk);
                #1;
            end
        end
        set_start(sel, 1'b0);
        check($sformatf("done_lat_d%0d", sel), done_of(sel), 1);
        check($sformatf("busy_end_d%0d", sel), busy_of(sel), 0);
        check($sformatf("abc_end_d%0d", sel), abc_of(sel), 0);
        @(negedge clk);
        #1;
        check($sformatf("done_cnt_d%0d", sel), dcnt_of(sel), d0 + 1);
        @(posedge clk);
        #1;
        check($sformatf("done_pulse_d%0d", sel), done_of(sel), 0);
        check($sformatf("pass_hold_d%0d", sel), pass_of(sel), e.pass);
    endtask

    initial begin
        int d0;
        rst_n  = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        start3 = 1'b0; abort3 = 1'b0;
        mode   = 0;
        repeat (2) @(negedge clk);
        check("rst_abc1", {a1, b1, c1}, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_res1", {pass1, tt1, err1, ff1, fv1}, 0);
        check("rst_res3", {busy3, pass3, tt3, err3, ff3, fv3}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(1, 0, 1, 0);
        sweep(1, 1, 1, 0);
        sweep(1, 2, 1, 0);
        sweep(3, 0, 3, 0);
        sweep(3, 2, 3, 0);

        // abort while vector 4 is on the gate
        mode = 0;
        d0 = dcnt1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_at_v4", {a1, b1, c1}, 4);
        abort1 = 1'b1;
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        check("abort_busy", busy1, 0);
        check("abort_abc", {a1, b1, c1}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", dcnt1, d0);
        check("abort_tt", tt1, 8'h01);
        check("abort_err", err1, 0);
        check("abort_pass", pass1, 0);

        sweep(1, 0, 1, 0);
        sweep(1, 0, 1, 1);
        sweep(3, 1, 3, 1);

        // asynchronous reset in the middle of vector 5
        mode = 0;
        d0 = dcnt1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_v5", {a1, b1, c1}, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_abc", {a1, b1, c1}, 0);
        check("arst_busy", busy1, 0);
        check("arst_done", done1, 0);
        check("arst_pass", pass1, 0);
        check("arst_tt", tt1, 0);
        check("arst_err", err1, 0);
        check("arst_fail", {ff1, fv1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("arst_no_done", dcnt1, d0);
        check("arst_idle_busy", busy1, 0);

        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
